axi_line_arb: RTL and testbench
===============================

// Module: axi_line_arb
// PURPOSE
//  N-port cache-line arbiter/buffer between L1 caches and the axi_rw burst master.
//  Round-robin grant. The granted line (LINE_BITS) is moved as LINE_BITS/DATA_W beats.
//  Reads fill a line buffer, then return the whole line in one cycle with a done pulse.
//  Writes load the line once, then stream it beat-by-beat.
//  Replaces the fixed 2-port/512-bit controller: per-port error reporting, no external FIFO index.
// PARAMETERS
//  N_PORTS    2    number of requesting ports (1..8)
//  ADDR_W     64   address width
//  DATA_W     64   AXI beat width
//  LINE_BITS  512  cache line width; multiple of DATA_W
//  BEATS      LINE_BITS/DATA_W (localparam); burst len field = BEATS-1
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  async active-high reset
//  p_req        in   N_PORTS            per-port request, held high until p_done
//  p_we         in   N_PORTS            1=write line, 0=read line
//  p_addr       in   N_PORTS*ADDR_W     line-aligned address, port i at [i*ADDR_W+:ADDR_W]
//  p_wdata      in   N_PORTS*LINE_BITS  write line per port
//  p_rdata      out  LINE_BITS          line buffer; valid in p_done cycle until next grant
//  p_done       out  N_PORTS            1-cycle completion pulse to granted port
//  p_err        out  N_PORTS            with p_done: any RRESP/BRESP != OKAY
//  m_valid      out  1                  burst command valid
//  m_ready      in   1                  master accepts command (handshake m_valid&m_ready)
//  m_we         out  1                  command direction
//  m_addr       out  ADDR_W             command address
//  m_len        out  8                  BEATS-1
//  m_rvalid     in   1                  read beat valid
//  m_rdata      in   DATA_W             read beat data
//  m_rresp      in   2                  read beat response
//  m_rlast      in   1                  last read beat
//  m_wready     in   1                  master consumes current write beat
//  m_wdata      out  DATA_W             current write beat
//  m_wlast      out  1                  beat_cnt==BEATS-1 in S_WBEAT
//  m_bvalid     in   1                  write response valid
//  m_bresp      in   2                  write response
// BEHAVIOUR
//  Reset (async): state=S_IDLE, rr_ptr=0, beat_cnt=0, err_acc=0, buffer=0.
//   All outputs 0 while rst; a transfer in flight is abandoned, no p_done issued.
//  States:
//   S_IDLE: grant first p_req bit at/after rr_ptr (wrap). Latch grant idx, we, addr.
//    Write: latch p_wdata into buffer. -> S_CMD. No req: stay.
//   S_CMD: m_valid=1, fields stable. On m_ready -> S_RBEAT or S_WBEAT, beat_cnt=0.
//   S_RBEAT: on m_rvalid, buffer[beat_cnt*DATA_W+:DATA_W]<=m_rdata, beat_cnt++, err_acc|=(m_rresp!=0).
//    m_rlast or beat_cnt==BEATS-1 on a valid beat -> S_DONE. Either ends the burst;
//    remaining buffer beats keep old data.
//   S_WBEAT: m_wdata=buffer[beat_cnt*DATA_W+:DATA_W]. On m_wready beat_cnt++; after last beat -> S_BRESP.
//   S_BRESP: on m_bvalid, err_acc|=(m_bresp!=0) -> S_DONE.
//   S_DONE: p_done[grant]=1, p_err[grant]=err_acc for exactly one cycle.
//    rr_ptr<=grant+1 (mod N_PORTS), err_acc<=0 -> S_IDLE.
//  Latency: grant to m_valid = 1 cycle. Final beat/bresp to p_done = 1 cycle.
//   Min read: 1 + cmd + BEATS + 1 cycles.
//  Fairness: port just served has lowest priority next grant. Ports starve for at most N_PORTS-1 grants.
//  Simultaneous requests in S_IDLE: RR order decides. Requests arriving mid-transfer wait.
//  p_req dropped before p_done: transfer still completes, p_done still pulses.
//  m_rvalid/m_wready/m_bvalid outside matching state: ignored.
//  beat_cnt width = $clog2(BEATS)+1; no wrap within a burst.
// STRUCTURE
//  Package axi_line_pkg: state enum (S_IDLE,S_CMD,S_RBEAT,S_WBEAT,S_BRESP,S_DONE), RESP_OKAY=2'b00.
//  Sub-module rr_arbiter (N_PORTS param: req, ptr -> one-hot grant + index), combinational.
//  Line buffer and beat mux stay in this module.
// TESTING
//  N=2,512b: port0 read 0x8000_0000, 8 beats 0x0..0x7 -> p_rdata words 0..7, p_done[0] 1 cycle, p_err=0.
//  Both p_req at once, rr_ptr=0 -> port0 then port1; repeat -> port1 then port0.
//  Write 0x1000 line {8{0xA5A5..}}, m_wready toggling -> 8 beats, m_wlast only on 8th, done after bvalid.
//  Read with beat3 m_rresp=2'b10 -> p_done with p_err=1; next transfer p_err=0.
//  Assert rst during S_RBEAT beat 4 -> all outputs 0 immediately, no p_done; next read completes normally.
//  N_PORTS=4, DATA_W=32, LINE_BITS=256: all ports requesting -> grants 0,1,2,3,0; m_len=7.

Source files
------------

// File: rtl/axi_line_pkg.sv
// ---------------------------------------------------------------------------
// axi_line_pkg
//   Shared types and constants for the cache-line arbiter/buffer.
//   - state_t   : controller state encoding
//   - RESP_OKAY : AXI OKAY response code
//   - resp_err  : flags any non-OKAY response
// ---------------------------------------------------------------------------
package axi_line_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RBEAT,
        S_WBEAT,
        S_BRESP,
        S_DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic resp_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_line_arb_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: the first asserted req bit at or after
//   ptr, wrapping around N_PORTS.
//   Ports:
//     req   in  N_PORTS  request vector
//     ptr   in  PW       highest-priority port index (must be < N_PORTS)
//     grant out N_PORTS  one-hot grant (zero when no request)
//     idx   out PW       index of granted port
//     valid out 1        some request was granted
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_PORTS = 2,
    parameter int PW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [N_PORTS-1:0] grant,
    output logic [PW-1:0]      idx,
    output logic               valid
);

    always_comb begin
        int s;
        s     = 0;
        valid = 1'b0;
        idx   = '0;
        grant = '0;
        for (int off = 0; off < N_PORTS; off++) begin
            // Candidate port (ptr + off) mod N_PORTS without a divider.
            s = int'(ptr) + off;
            if (s >= N_PORTS) s = s - N_PORTS;
            for (int i = 0; i < N_PORTS; i++) begin
                if (!valid && (s == i) && req[i]) begin
                    valid    = 1'b1;
                    idx      = PW'(i);
                    grant[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axi_line_arb.sv
// ---------------------------------------------------------------------------
// axi_line_arb
//   N-port cache-line arbiter/buffer in front of a burst master. One port is
//   granted round-robin; its line moves as BEATS = LINE_BITS/DATA_W beats.
//   Reads collect beats into the line buffer and hand back the whole line
//   with a p_done pulse; writes load the line once and stream it out.
//   Ports:
//     clk, rst                 clock, async active-high reset
//     p_req/p_we/p_addr/p_wdata per-port request, direction, address, line
//     p_rdata                  line buffer (valid from p_done to next grant)
//     p_done/p_err             one-cycle completion and error to grantee
//     m_valid/m_ready/m_we/m_addr/m_len  burst command handshake
//     m_rvalid/m_rdata/m_rresp/m_rlast   read beat channel
//     m_wready/m_wdata/m_wlast           write beat channel
//     m_bvalid/m_bresp                   write response
// ---------------------------------------------------------------------------
module axi_line_arb
    import axi_line_pkg::*;
#(
    parameter int N_PORTS   = 2,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int LINE_BITS = 512
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_PORTS-1:0]             p_req,
    input  logic [N_PORTS-1:0]             p_we,
    input  logic [N_PORTS*ADDR_W-1:0]      p_addr,
    input  logic [N_PORTS*LINE_BITS-1:0]   p_wdata,
    output logic [LINE_BITS-1:0]           p_rdata,
    output logic [N_PORTS-1:0]             p_done,
    output logic [N_PORTS-1:0]             p_err,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           m_we,
    output logic [ADDR_W-1:0]              m_addr,
    output logic [7:0]                     m_len,
    input  logic                           m_rvalid,
    input  logic [DATA_W-1:0]              m_rdata,
    input  logic [1:0]                     m_rresp,
    input  logic                           m_rlast,
    input  logic                           m_wready,
    output logic [DATA_W-1:0]              m_wdata,
    output logic                           m_wlast,
    input  logic                           m_bvalid,
    input  logic [1:0]                     m_bresp
);

    localparam int BEATS = LINE_BITS / DATA_W;
    localparam int CW    = $clog2(BEATS) + 1;
    localparam int PW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [7:0]    LEN       = 8'(BEATS - 1);

    state_t                 state;
    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          grant_idx;
    logic [N_PORTS-1:0]     grant_oh;
    logic                   we_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [7:0]             len_q;
    logic [CW-1:0]          beat_cnt;
    logic                   err_acc;
    logic [LINE_BITS-1:0]   line_buf;

    logic [N_PORTS-1:0]     arb_grant;
    logic [PW-1:0]          arb_idx;
    logic                   arb_valid;

    logic                   sel_we;
    logic [ADDR_W-1:0]      sel_addr;
    logic [LINE_BITS-1:0]   sel_wdata;
    logic [DATA_W-1:0]      beat_mux;

    rr_arbiter #(
        .N_PORTS (N_PORTS),
        .PW      (PW)
    ) u_rr (
        .req   (p_req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Request fields of the port the arbiter is currently pointing at.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (arb_idx == PW'(i)) begin
                sel_we    = p_we[i];
                sel_addr  = p_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = p_wdata[i*LINE_BITS +: LINE_BITS];
            end
        end
    end

    // Current write beat out of the line buffer.
    always_comb begin
        beat_mux = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_cnt == CW'(b)) beat_mux = line_buf[b*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            grant_oh  <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            err_acc   <= 1'b0;
            line_buf  <= '0;
        end else begin
            len_q <= LEN;
            case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        grant_idx <= arb_idx;
                        grant_oh  <= arb_grant;
                        we_q      <= sel_we;
                        addr_q    <= sel_addr;
                        if (sel_we) line_buf <= sel_wdata;
                        state     <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (m_ready) begin
                        beat_cnt <= '0;
                        state    <= we_q ? S_WBEAT : S_RBEAT;
                    end
                end
                S_RBEAT: begin
                    if (m_rvalid) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (beat_cnt == CW'(b)) line_buf[b*DATA_W +: DATA_W] <= m_rdata;
                        end
                        beat_cnt <= beat_cnt + 1'b1;
                        err_acc  <= err_acc | resp_err(m_rresp);
                        // An early rlast ends the burst; untouched beats keep old data.
                        if (m_rlast || beat_cnt == LAST_BEAT) state <= S_DONE;
                    end
                end
                S_WBEAT: begin
                    if (m_wready) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) state <= S_BRESP;
                    end
                end
                S_BRESP: begin
                    if (m_bvalid) begin
                        err_acc <= err_acc | resp_err(m_bresp);
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Port just served drops to lowest priority.
                    rr_ptr  <= (grant_idx == PW'(N_PORTS - 1)) ? '0 : grant_idx + 1'b1;
                    err_acc <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign p_rdata = line_buf;
    assign p_done  = (state == S_DONE) ? grant_oh : '0;
    assign p_err   = p_done & {N_PORTS{err_acc}};
    assign m_valid = (state == S_CMD);
    assign m_we    = we_q;
    assign m_addr  = addr_q;
    assign m_len   = len_q;
    assign m_wdata = (state == S_WBEAT) ? beat_mux : '0;
    assign m_wlast = (state == S_WBEAT) && (beat_cnt == LAST_BEAT);

endmodule

// File: tb/tb_axi_line_arb.sv
module tb_axi_line_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- DUT A: 2 ports, 64-bit beats, 512-bit line ----------------
    logic [1:0]    a_req, a_we, a_done, a_err;
    logic [127:0]  a_addr;
    logic [1023:0] a_wdata;
    logic [511:0]  a_prdata;
    logic          a_mvalid, a_mready, a_mwe;
    logic [63:0]   a_maddr;
    logic [7:0]    a_mlen;
    logic          a_rvalid, a_rlast, a_wready, a_wlast, a_bvalid;
    logic [63:0]   a_rdata, a_wdata_o;
    logic [1:0]    a_rresp, a_bresp;

    axi_line_arb #(.N_PORTS(2), .ADDR_W(64), .DATA_W(64), .LINE_BITS(512)) dut_a (
        .clk(clk), .rst(rst),
        .p_req(a_req), .p_we(a_we), .p_addr(a_addr), .p_wdata(a_wdata),
        .p_rdata(a_prdata), .p_done(a_done), .p_err(a_err),
        .m_valid(a_mvalid), .m_ready(a_mready), .m_we(a_mwe), .m_addr(a_maddr), .m_len(a_mlen),
        .m_rvalid(a_rvalid), .m_rdata(a_rdata), .m_rresp(a_rresp), .m_rlast(a_rlast),
        .m_wready(a_wready), .m_wdata(a_wdata_o), .m_wlast(a_wlast),
        .m_bvalid(a_bvalid), .m_bresp(a_bresp)
    );

    // ---------------- DUT B: 4 ports, 32-bit beats, 256-bit line ----------------
    logic [3:0]    b_req, b_we, b_done, b_err;
    logic [255:0]  b_addr;
    logic [1023:0] b_wdata;
    logic [255:0]  b_prdata;
    logic          b_mvalid, b_mready, b_mwe;
    logic [63:0]   b_maddr;
    logic [7:0]    b_mlen;
    logic          b_rvalid, b_rlast, b_wready, b_wlast, b_bvalid;
    logic [31:0]   b_rdata, b_wdata_o;
    logic [1:0]    b_rresp, b_bresp;

    axi_line_arb #(.N_PORTS(4), .ADDR_W(64), .DATA_W(32), .LINE_BITS(256)) dut_b (
        .clk(clk), .rst(rst),
        .p_req(b_req), .p_we(b_we), .p_addr(b_addr), .p_wdata(b_wdata),
        .p_rdata(b_prdata), .p_done(b_done), .p_err(b_err),
        .m_valid(b_mvalid), .m_ready(b_mready), .m_we(b_mwe), .m_addr(b_maddr), .m_len(b_mlen),
        .m_rvalid(b_rvalid), .m_rdata(b_rdata), .m_rresp(b_rresp), .m_rlast(b_rlast),
        .m_wready(b_wready), .m_wdata(b_wdata_o), .m_wlast(b_wlast),
        .m_bvalid(b_bvalid), .m_bresp(b_bresp)
    );

    function automatic logic [511:0] line_of(input logic [63:0] base);
        logic [511:0] l;
        for (int b = 0; b < 8; b++) l[b*64 +: 64] = base + 64'(b);
        return l;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Plays the master side of one read on DUT A; returns what was observed.
    task automatic a_read_xfer(input logic [63:0] base, input int errbeat, input logic [1:0] drop,
                               output logic got, output logic [63:0] addr, output logic mwe,
                               output logic [1:0] done, output logic [1:0] err,
                               output logic [1:0] done_next, output logic [511:0] rd);
        got = 1'b0; addr = '0; mwe = 1'b0; done = '0; err = '0; done_next = '0; rd = '0;
        for (int i = 0; i < 20; i++) begin
            if (a_mvalid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (got) begin
            addr = a_maddr;
            mwe  = a_mwe;
            a_mready = 1'b1;
            @(negedge clk);
            a_mready = 1'b0;
            for (int b = 0; b < 8; b++) begin
                a_rvalid = 1'b1;
                a_rdata  = base + 64'(b);
                a_rresp  = (b == errbeat) ? 2'b10 : 2'b00;
                a_rlast  = (b == 7);
                @(negedge clk);
            end
            a_rvalid = 1'b0; a_rlast = 1'b0; a_rresp = 2'b00;
            done = a_done;
            err  = a_err;
            rd   = a_prdata;
            a_req = a_req & ~drop;
            @(negedge clk);
            done_next = a_done;
        end else begin
            a_req = a_req & ~drop;
        end
    endtask

    // Plays the master side of one write on DUT A with m_wready toggling.
    task automatic a_write_xfer(input logic [511:0] line, input logic [1:0] bresp,
                                output logic got, output logic [63:0] addr, output logic mwe,
                                output int nbeats, output int bad_data, output int bad_last,
                                output int early_done, output logic [1:0] done, output logic [1:0] err);
        logic [63:0] expw;
        logic        w;
        got = 1'b0; addr = '0; mwe = 1'b0; nbeats = 0; bad_data = 0; bad_last = 0;
        early_done = 0; done = '0; err = '0;
        for (int i = 0; i < 20; i++) begin
            if (a_mvalid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (got) begin
            addr = a_maddr;
            mwe  = a_mwe;
            a_mready = 1'b1;
            @(negedge clk);
            a_mready = 1'b0;
            for (int k = 0; k < 40 && nbeats < 8; k++) begin
                w = k[0];
                if (a_done != 2'b00) early_done++;
                if (w) begin
                    expw = '0;
                    for (int b = 0; b < 8; b++) if (b == nbeats) expw = line[b*64 +: 64];
                    if (a_wdata_o !== expw) bad_data++;
                    if (a_wlast !== (nbeats == 7)) bad_last++;
                    nbeats++;
                end else if (a_wlast && nbeats != 7) begin
                    bad_last++;
                end
                a_wready = w;
                @(negedge clk);
            end
            a_wready = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (a_done != 2'b00) early_done++;
                @(negedge clk);
            end
            a_bvalid = 1'b1;
            a_bresp  = bresp;
            @(negedge clk);
            a_bvalid = 1'b0;
            a_bresp  = 2'b00;
            done = a_done;
            err  = a_err;
        end
        a_req = 2'b00;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (a_mvalid !== 1'b0) begin n_bad++; $display("FAIL rst_mvalid: got %b want 0", a_mvalid); end
        n_cmp++; if (a_done !== 2'b00) begin n_bad++; $display("FAIL rst_done: got %b want 00", a_done); end
        n_cmp++; if (a_prdata !== 512'd0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", a_prdata); end
        n_cmp++; if (a_mlen !== 8'd0) begin n_bad++; $display("FAIL rst_mlen: got %0d want 0", a_mlen); end
        n_cmp++; if (a_maddr !== 64'd0) begin n_bad++; $display("FAIL rst_maddr: got %h want 0", a_maddr); end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (a_mvalid !== 1'b0) begin n_bad++; $display("FAIL idle_mvalid: got %b want 0", a_mvalid); end
        n_cmp++; if (a_mlen !== 8'd7) begin n_bad++; $display("FAIL idle_mlen: got %0d want 7", a_mlen); end
    endtask

    task automatic test_read();
        logic got, mwe;
        logic [63:0] addr;
        logic [1:0] done, err, dn;
        logic [511:0] rd;
        a_addr[63:0] = 64'h8000_0000;
        a_we  = 2'b00;
        a_req = 2'b01;
        a_read_xfer(64'h0, -1, 2'b01, got, addr, mwe, done, err, dn, rd);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL read_cmd: got %b want 1 (timeout)", got); end
        n_cmp++; if (addr !== 64'h8000_0000) begin n_bad++; $display("FAIL read_addr: got %h want 80000000", addr); end
        n_cmp++; if (mwe !== 1'b0) begin n_bad++; $display("FAIL read_mwe: got %b want 0", mwe); end
        n_cmp++; if (done !== 2'b01) begin n_bad++; $display("FAIL read_done: got %b want 01", done); end
        n_cmp++; if (err !== 2'b00) begin n_bad++; $display("FAIL read_err: got %b want 00", err); end
        n_cmp++; if (rd !== line_of(64'h0)) begin n_bad++; $display("FAIL read_data: got %h want %h", rd, line_of(64'h0)); end
        n_cmp++; if (dn !== 2'b00) begin n_bad++; $display("FAIL read_done_width: got %b want 00", dn); end
    endtask

    task automatic test_rr();
        logic got, mwe;
        logic [63:0] addr;
        logic [1:0] done, err, dn;
        logic [511:0] rd;
        do_reset();
        a_addr = {64'h200, 64'h100};
        a_we   = 2'b00;
        // Round 1 from rr_ptr=0: port0 then port1.
        a_req = 2'b11;
        a_read_xfer(64'h10, -1, 2'b01, got, addr, mwe, done, err, dn, rd);
        n_cmp++; if (addr !== 64'h100 || done !== 2'b01) begin n_bad++; $display("FAIL rr1_first: got addr %h done %b want 100 01", addr, done); end
        a_read_xfer(64'h20, -1, 2'b10, got, addr, mwe, done, err, dn, rd);
        n_cmp++; if (addr !== 64'h200 || done !== 2'b10) begin n_bad++; $display("FAIL rr1_second: got addr %h done %b want 200 10", addr, done); end
        n_cmp++; if (rd !== line_of(64'h20)) begin n_bad++; $display("FAIL rr1_data: got %h want %h", rd, line_of(64'h20)); end
        // Serve port0 alone, leaving port1 highest priority.
        a_req = 2'b01;
        a_read_xfer(64'h30, -1, 2'b01, got, addr, mwe, done, err, dn, rd);
        n_cmp++; if (addr !== 64'h100) begin n_bad++; $display("FAIL rr_single: got addr %h want 100", addr); end
        // Round 2: port1 then port0.
        a_req = 2'b11;
        a_read_xfer(64'h40, -1, 2'b10, got, addr, mwe, done, err, dn, rd);
        n_cmp++; if (addr !== 64'h200 || done !== 2'b10) begin n_bad++; $display("FAIL rr2_first: got addr %h done %b want 200 10", addr, done); end
        a_read_xfer(64'h50, -1, 2'b01, got, addr, mwe, done, err, dn, rd);
        n_cmp++; if (addr !== 64'h100 || done !== 2'b01) begin n_bad++; $display("FAIL rr2_second: got addr %h done %b want 100 01", addr, done); end
    endtask

    task automatic test_write();
        logic got, mwe;
        logic [63:0] addr;
        logic [1:0] done, err;
        logic [511:0] line;
        int nb, bd, bl, ed;
        a_addr[63:0] = 64'h1000;
        a_we  = 2'b01;
        line  = {8{64'hA5A5_A5A5_A5A5_A5A5}};
        a_wdata[511:0] = line;
        a_req = 2'b01;
        a_write_xfer(line, 2'b00, got, addr, mwe, nb, bd, bl, ed, done, err);
        n_cmp++; if (got !== 1'b1 || addr !== 64'h1000 || mwe !== 1'b1) begin n_bad++; $display("FAIL wr_cmd: got %b addr %h we %b want 1 1000 1", got, addr, mwe); end
        n_cmp++; if (nb !== 8) begin n_bad++; $display("FAIL wr_beats: got %0d want 8", nb); end
        n_cmp++; if (bd !== 0) begin n_bad++; $display("FAIL wr_data: got %0d bad beats want 0", bd); end
        n_cmp++; if (bl !== 0) begin n_bad++; $display("FAIL wr_wlast: got %0d bad wlast want 0", bl); end
        n_cmp++; if (ed !== 0) begin n_bad++; $display("FAIL wr_early_done: got %0d want 0", ed); end
        n_cmp++; if (done !== 2'b01 || err !== 2'b00) begin n_bad++; $display("FAIL wr_done: got done %b err %b want 01 00", done, err); end
        // Distinct beats catch beat-order errors; SLVERR on BRESP reports p_err.
        for (int b = 0; b < 8; b++) line[b*64 +: 64] = 64'h1111_0000_0000_0000 * 64'(b + 1) + 64'(b);
        a_wdata[511:0] = line;
        a_req = 2'b01;
        a_write_xfer(line, 2'b10, got, addr, mwe, nb, bd, bl, ed, done, err);
        n_cmp++; if (nb !== 8 || bd !== 0 || bl !== 0) begin n_bad++; $display("FAIL wr2_beats: got n %0d bad %0d last %0d want 8 0 0", nb, bd, bl); end
        n_cmp++; if (done !== 2'b01 || err !== 2'b01) begin n_bad++; $display("FAIL wr2_bresp_err: got done %b err %b want 01 01", done, err); end
        a_we = 2'b00;
    endtask

    task automatic test_err();
        logic got, mwe;
        logic [63:0] addr;
        logic [1:0] done, err, dn;
        logic [511:0] rd;
        a_addr[63:0] = 64'h8000_0000;
        a_we  = 2'b00;
        a_req = 2'b01;
        a_read_xfer(64'h60, 3, 2'b01, got, addr, mwe, done, err, dn, rd);
        n_cmp++; if (done !== 2'b01 || err !== 2'b01) begin n_bad++; $display("FAIL rresp_err: got done %b err %b want 01 01", done, err); end
        n_cmp++; if (rd !== line_of(64'h60)) begin n_bad++; $display("FAIL rresp_data: got %h want %h", rd, line_of(64'h60)); end
        a_req = 2'b01;
        a_read_xfer(64'h70, -1, 2'b01, got, addr, mwe, done, err, dn, rd);
        n_cmp++; if (done !== 2'b01 || err !== 2'b00) begin n_bad++; $display("FAIL err_cleared: got done %b err %b want 01 00", done, err); end
    endtask

    task automatic test_reset_mid();
        logic got, mwe;
        logic [63:0] addr;
        logic [1:0] done, err, dn;
        logic [511:0] rd;
        int seen;
        a_addr[63:0] = 64'h8000_0000;
        a_we  = 2'b00;
        a_req = 2'b01;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (a_mvalid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL rstmid_cmd: got %b want 1 (timeout)", got); end
        a_mready = 1'b1;
        @(negedge clk);
        a_mready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            a_rvalid = 1'b1;
            a_rdata  = 64'h90 + 64'(b);
            @(negedge clk);
        end
        a_rdata = 64'h94;
        rst   = 1'b1;
        a_req = 2'b00;
        #1;
        n_cmp++; if (a_mvalid !== 1'b0 || a_done !== 2'b00 || a_err !== 2'b00) begin n_bad++; $display("FAIL rstmid_ctrl: got mvalid %b done %b err %b want 0 00 00", a_mvalid, a_done, a_err); end
        n_cmp++; if (a_prdata !== 512'd0 || a_maddr !== 64'd0 || a_mlen !== 8'd0) begin n_bad++; $display("FAIL rstmid_data: got rdata %h addr %h len %0d want 0", a_prdata, a_maddr, a_mlen); end
        @(negedge clk);
        a_rvalid = 1'b0;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (a_done != 2'b00 || a_mvalid) seen++;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", seen); end
        a_req = 2'b01;
        a_read_xfer(64'hA0, -1, 2'b01, got, addr, mwe, done, err, dn, rd);
        n_cmp++; if (got !== 1'b1 || done !== 2'b01 || err !== 2'b00) begin n_bad++; $display("FAIL rstmid_next: got cmd %b done %b err %b want 1 01 00", got, done, err); end
        n_cmp++; if (rd !== line_of(64'hA0)) begin n_bad++; $display("FAIL rstmid_next_data: got %h want %h", rd, line_of(64'hA0)); end
    endtask

    task automatic test_four_port_rr();
        logic got;
        logic [255:0] expl;
        int p;
        for (int i = 0; i < 4; i++) b_addr[i*64 +: 64] = 64'h4000 + 64'(i) * 64'h100;
        b_we  = 4'h0;
        b_req = 4'hF;
        for (int t = 0; t < 5; t++) begin
            p = t % 4;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (b_mvalid) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL b_cmd%0d: got %b want 1 (timeout)", t, got); end
            n_cmp++; if (b_maddr !== 64'h4000 + 64'(p) * 64'h100) begin n_bad++; $display("FAIL b_grant%0d: got addr %h want port %0d", t, b_maddr, p); end
            n_cmp++; if (b_mlen !== 8'd7) begin n_bad++; $display("FAIL b_mlen%0d: got %0d want 7", t, b_mlen); end
            if (got) begin
                b_mready = 1'b1;
                @(negedge clk);
                b_mready = 1'b0;
                for (int b = 0; b < 8; b++) begin
                    b_rvalid = 1'b1;
                    b_rdata  = 32'(t * 16 + b);
                    b_rlast  = (b == 7);
                    expl[b*32 +: 32] = 32'(t * 16 + b);
                    @(negedge clk);
                end
                b_rvalid = 1'b0;
                b_rlast  = 1'b0;
                n_cmp++; if (b_done !== 4'(1 << p)) begin n_bad++; $display("FAIL b_done%0d: got %b want port %0d", t, b_done, p); end
                n_cmp++; if (b_prdata !== expl) begin n_bad++; $display("FAIL b_data%0d: got %h want %h", t, b_prdata, expl); end
                @(negedge clk);
            end
        end
        b_req = 4'h0;
    endtask

    initial begin
        rst = 1'b1;
        a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
        a_mready = 1'b0; a_rvalid = 1'b0; a_rdata = '0; a_rresp = '0; a_rlast = 1'b0;
        a_wready = 1'b0; a_bvalid = 1'b0; a_bresp = '0;
        b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
        b_mready = 1'b0; b_rvalid = 1'b0; b_rdata = '0; b_rresp = '0; b_rlast = 1'b0;
        b_wready = 1'b0; b_bvalid = 1'b0; b_bresp = '0;

        test_reset();
        test_read();
        test_rr();
        test_write();
        test_err();
        test_reset_mid();
        test_four_port_rr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
